// File: rtl/icb2axi_pipe.sv
// icb2axi_pipe: single-beat ICB-to-AXI4 bridge with a registered command stage.
//
// A command accepted on ICB is captured into one hold register. The AXI
// AR or AW/W valids are driven straight from flags in that register, so
// they never depend on any ready. Responses return to ICB in command order.
// A 1-bit order FIFO records read (1) or write (0) for each accepted command.
//
// Ports
//   clk, rst               rising-edge clock; asynchronous active-low reset
//   i_icb_cmd_*            ICB command channel (valid/ready/read/addr/wdata/wmask/size)
//   i_icb_rsp_*            ICB response channel (valid/ready/err/rdata)
//   o_axi_ar*, o_axi_aw*   AXI address channels (single beat, len 0, fixed attributes)
//   o_axi_w*               AXI write data channel (wlast always 1)
//   o_axi_r*, o_axi_b*     AXI read data and write response channels
//   o_outs_cnt             accepted-but-unresponded transaction count
//   o_proto_err            sticky flag: an R beat arrived with rlast=0
module icb2axi_pipe #(
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int OUTS_NUM = 8,
  parameter int LOCKW    = 1,
  parameter int AXILENW  = 8,
  parameter int CNTW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_icb_cmd_valid,
  output logic               i_icb_cmd_ready,
  input  logic               i_icb_cmd_read,
  input  logic [AW-1:0]      i_icb_cmd_addr,
  input  logic [DW-1:0]      i_icb_cmd_wdata,
  input  logic [DW/8-1:0]    i_icb_cmd_wmask,
  input  logic [2:0]         i_icb_cmd_size,
  output logic               i_icb_rsp_valid,
  input  logic               i_icb_rsp_ready,
  output logic               i_icb_rsp_err,
  output logic [DW-1:0]      i_icb_rsp_rdata,
  output logic               o_axi_arvalid,
  input  logic               o_axi_arready,
  output logic [AW-1:0]      o_axi_araddr,
  output logic [3:0]         o_axi_arcache,
  output logic [2:0]         o_axi_arprot,
  output logic [LOCKW-1:0]   o_axi_arlock,
  output logic [1:0]         o_axi_arburst,
  output logic [AXILENW-1:0] o_axi_arlen,
  output logic [2:0]         o_axi_arsize,
  output logic               o_axi_awvalid,
  input  logic               o_axi_awready,
  output logic [AW-1:0]      o_axi_awaddr,
  output logic [3:0]         o_axi_awcache,
  output logic [2:0]         o_axi_awprot,
  output logic [LOCKW-1:0]   o_axi_awlock,
  output logic [1:0]         o_axi_awburst,
  output logic [AXILENW-1:0] o_axi_awlen,
  output logic [2:0]         o_axi_awsize,
  output logic               o_axi_wvalid,
  input  logic               o_axi_wready,
  output logic [DW-1:0]      o_axi_wdata,
  output logic [DW/8-1:0]    o_axi_wstrb,
  output logic               o_axi_wlast,
  input  logic               o_axi_rvalid,
  output logic               o_axi_rready,
  input  logic [DW-1:0]      o_axi_rdata,
  input  logic [1:0]         o_axi_rresp,
  input  logic               o_axi_rlast,
  input  logic               o_axi_bvalid,
  output logic               o_axi_bready,
  input  logic [1:0]         o_axi_bresp,
  output logic [CNTW-1:0]    o_outs_cnt,
  output logic               o_proto_err
);

  localparam int SZMAX = $clog2(DW/8);
  localparam int PTRW  = $clog2(OUTS_NUM);

  // Beats wider than the bus are clamped to the bus width.
  function automatic logic [2:0] sat_size(input logic [2:0] sz);
    if (sz > 3'(SZMAX)) return 3'(SZMAX);
    return sz;
  endfunction

  logic [AW-1:0]   addr_p0;
  logic [DW-1:0]   data_p0;
  logic [DW/8-1:0] mask_p0;
  logic [2:0]      size_p0;
  logic            ar_vld_p0, aw_vld_p0, w_vld_p0;

  logic            ord_mem [OUTS_NUM];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] ord_cnt;

  logic hold_free, ord_full, nonempty, head;
  logic cmd_hs, rsp_hs, r_hs;
  logic unused_resp;

  assign unused_resp = ^{o_axi_rresp[0], o_axi_bresp[0]};

  // Hold stage is free when every pending channel completes this cycle.
  assign hold_free = (~ar_vld_p0 | o_axi_arready) &
                     (~aw_vld_p0 | o_axi_awready) &
                     (~w_vld_p0  | o_axi_wready);

  assign nonempty = (ord_cnt != '0);
  assign head     = ord_mem[rd_ptr];
  assign rsp_hs   = i_icb_rsp_valid & i_icb_rsp_ready;
  assign r_hs     = o_axi_rvalid & o_axi_rready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign ord_full = (ord_cnt == CNTW'(OUTS_NUM)) & ~rsp_hs;

  assign i_icb_cmd_ready = rst & hold_free & ~ord_full;
  assign cmd_hs          = i_icb_cmd_valid & i_icb_cmd_ready;

  // ---- stage p0: command hold register (data, no reset) ----
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_p0         <= i_icb_cmd_addr;
      data_p0         <= i_icb_cmd_wdata;
      mask_p0         <= i_icb_cmd_wmask;
      size_p0         <= i_icb_cmd_size;
      ord_mem[wr_ptr] <= i_icb_cmd_read;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_vld_p0   <= 1'b0;
      aw_vld_p0   <= 1'b0;
      w_vld_p0    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ord_cnt     <= '0;
      o_proto_err <= 1'b0;
    end else begin
      if (cmd_hs) begin
        ar_vld_p0 <= i_icb_cmd_read;
        aw_vld_p0 <= ~i_icb_cmd_read;
        w_vld_p0  <= ~i_icb_cmd_read;
        wr_ptr    <= wr_ptr + 1'b1;
      end else begin
        ar_vld_p0 <= ar_vld_p0 & ~o_axi_arready;
        aw_vld_p0 <= aw_vld_p0 & ~o_axi_awready;
        w_vld_p0  <= w_vld_p0  & ~o_axi_wready;
      end
      if (rsp_hs) rd_ptr <= rd_ptr + 1'b1;
      case ({cmd_hs, rsp_hs})
        2'b10:   ord_cnt <= ord_cnt + 1'b1;
        2'b01:   ord_cnt <= ord_cnt - 1'b1;
        default: ord_cnt <= ord_cnt;
      endcase
      if (r_hs && !o_axi_rlast) o_proto_err <= 1'b1;
    end
  end

  // ---- stage p0 -> AXI request channels ----
  assign o_axi_arvalid = ar_vld_p0;
  assign o_axi_araddr  = addr_p0;
  assign o_axi_arcache = '0;
  assign o_axi_arprot  = '0;
  assign o_axi_arlock  = '0;
  assign o_axi_arburst = '0;
  assign o_axi_arlen   = '0;
  assign o_axi_arsize  = sat_size(size_p0);

  assign o_axi_awvalid = aw_vld_p0;
  assign o_axi_awaddr  = addr_p0;
  assign o_axi_awcache = '0;
  assign o_axi_awprot  = '0;
  assign o_axi_awlock  = '0;
  assign o_axi_awburst = '0;
  assign o_axi_awlen   = '0;
  assign o_axi_awsize  = sat_size(size_p0);

  assign o_axi_wvalid  = w_vld_p0;
  assign o_axi_wdata   = data_p0;
  assign o_axi_wstrb   = mask_p0;
  assign o_axi_wlast   = 1'b1;

  // ---- response path: only the channel matching the FIFO head is served ----
  assign o_axi_rready    = nonempty & head & i_icb_rsp_ready;
  assign o_axi_bready    = nonempty & ~head & i_icb_rsp_ready;
  assign i_icb_rsp_valid = nonempty & (head ? o_axi_rvalid : o_axi_bvalid);
  assign i_icb_rsp_err   = i_icb_rsp_valid &
                           (head ? (o_axi_rresp[1] | ~o_axi_rlast) : o_axi_bresp[1]);
  assign i_icb_rsp_rdata = (i_icb_rsp_valid & head) ? o_axi_rdata : '0;
  assign o_outs_cnt      = ord_cnt;

endmodule

// File: tb/tb_icb2axi_pipe.sv
module tb_icb2axi_pipe;
  localparam int AW = 32, DW = 64, OUTS_NUM = 8, LOCKW = 1, AXILENW = 8, CNTW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cmd_valid, cmd_ready, cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic [2:0] cmd_size;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic [AW-1:0] araddr, awaddr;
  logic [3:0] arcache, awcache;
  logic [2:0] arprot, awprot, arsize, awsize;
  logic [LOCKW-1:0] arlock, awlock;
  logic [1:0] arburst, awburst;
  logic [AXILENW-1:0] arlen, awlen;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic rvalid, rready, rlast, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [CNTW-1:0] outs_cnt;
  logic proto_err;

  icb2axi_pipe #(.AW(AW), .DW(DW), .OUTS_NUM(OUTS_NUM), .LOCKW(LOCKW),
                 .AXILENW(AXILENW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_cmd_size(cmd_size),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_err(rsp_err),
    .i_icb_rsp_rdata(rsp_rdata),
    .o_axi_arvalid(arvalid), .o_axi_arready(arready), .o_axi_araddr(araddr),
    .o_axi_arcache(arcache), .o_axi_arprot(arprot), .o_axi_arlock(arlock),
    .o_axi_arburst(arburst), .o_axi_arlen(arlen), .o_axi_arsize(arsize),
    .o_axi_awvalid(awvalid), .o_axi_awready(awready), .o_axi_awaddr(awaddr),
    .o_axi_awcache(awcache), .o_axi_awprot(awprot), .o_axi_awlock(awlock),
    .o_axi_awburst(awburst), .o_axi_awlen(awlen), .o_axi_awsize(awsize),
    .o_axi_wvalid(wvalid), .o_axi_wready(wready), .o_axi_wdata(wdata),
    .o_axi_wstrb(wstrb), .o_axi_wlast(wlast),
    .o_axi_rvalid(rvalid), .o_axi_rready(rready), .o_axi_rdata(rdata),
    .o_axi_rresp(rresp), .o_axi_rlast(rlast),
    .o_axi_bvalid(bvalid), .o_axi_bready(bready), .o_axi_bresp(bresp),
    .o_outs_cnt(outs_cnt), .o_proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW:0] sb [$];   // {err, rdata} in expected response order

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    logic [DW:0] e;
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_unexpected: observed response, expected none pending");
      end else begin
        e = sb.pop_front();
        chk("rsp_err", rsp_err, e[DW]);
        chk("rsp_rdata", rsp_rdata, e[DW-1:0]);
      end
    end
  endtask

  // Responses are scored at the falling edge; inputs change just after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_rsp();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW/8-1:0] m, input logic [2:0] sz);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m; cmd_size = sz;
  endtask

  function automatic logic [DW-1:0] rdat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    rst = 1'b0; cmd_valid = 0; cmd_read = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
    cmd_size = '0; rsp_ready = 1; arready = 1; awready = 1; wready = 1;
    rvalid = 0; rdata = '0; rresp = '0; rlast = 1; bvalid = 0; bresp = '0;
    @(posedge clk); #1;
    chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0); chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rready", rready, 0); chk("rst_bready", bready, 0);
    chk("rst_cnt", outs_cnt, 0); chk("rst_proto", proto_err, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single read
    cmd(1, 32'h8000_0010, '0, '0, 3'd2);
    #1 chk("t1_cmd_ready", cmd_ready, 1);
    sb.push_back({1'b0, 64'hDEAD_BEEF_0123_4567});
    tick();
    cmd_valid = 0;
    #1 chk("t1_arvalid", arvalid, 1); chk("t1_araddr", araddr, 32'h8000_0010);
    chk("t1_arsize", arsize, 2); chk("t1_arlen", arlen, 0); chk("t1_arburst", arburst, 0);
    chk("t1_cnt1", outs_cnt, 1);
    tick();
    #1 chk("t1_ar_drop", arvalid, 0);
    rvalid = 1; rdata = 64'hDEAD_BEEF_0123_4567; rresp = 0; rlast = 1;
    #1 chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rready", rready, 1);
    tick();
    rvalid = 0;
    #1 chk("t1_cnt0", outs_cnt, 0); chk("t1_rsp_idle", rsp_valid, 0);

    // Write with AW and W completing in different cycles, error response
    awready = 1; wready = 0;
    cmd(0, 32'h0000_1000, 64'h1122_3344_5566_7788, 8'h0F, 3'd3);
    sb.push_back({1'b1, 64'h0});
    tick();
    cmd_valid = 0;
    #1 chk("t2_awvalid1", awvalid, 1); chk("t2_wvalid1", wvalid, 1);
    chk("t2_cmd_ready1", cmd_ready, 0); chk("t2_wstrb", wstrb, 8'h0F);
    chk("t2_wdata", wdata, 64'h1122_3344_5566_7788); chk("t2_wlast", wlast, 1);
    chk("t2_awsize", awsize, 3); chk("t2_awaddr", awaddr, 32'h1000);
    tick();
    #1 chk("t2_awvalid2", awvalid, 0); chk("t2_wvalid2", wvalid, 1); chk("t2_cmd_ready2", cmd_ready, 0);
    tick();
    #1 chk("t2_wvalid3", wvalid, 1); chk("t2_cmd_ready3", cmd_ready, 0);
    tick();
    wready = 1;
    #1 chk("t2_wvalid4", wvalid, 1); chk("t2_cmd_ready4", cmd_ready, 1);
    tick();
    #1 chk("t2_wvalid5", wvalid, 0);
    bvalid = 1; bresp = 2'b10;
    #1 chk("t2_bready", bready, 1); chk("t2_rsp_valid", rsp_valid, 1);
    tick();
    bvalid = 0; bresp = 0;
    #1 chk("t2_cnt0", outs_cnt, 0);

    // Fill the order FIFO, then pop and accept in the same cycle
    for (int i = 0; i < OUTS_NUM; i++) begin
      cmd(1, 32'h100 + 32'(i * 8), '0, '0, (i == 0) ? 3'd7 : 3'd1);
      #1 chk("t3_cmd_ready", cmd_ready, 1);
      if (i == 1) chk("t3_arsize_sat", arsize, 3);
      if (i == 2) chk("t3_arsize_1", arsize, 1);
      sb.push_back({1'b0, rdat(i)});
      tick();
    end
    cmd(1, 32'h200, '0, '0, 3'd3);
    #1 chk("t3_full_ready", cmd_ready, 0); chk("t3_cnt8", outs_cnt, 8);
    tick();
    #1 chk("t3_full_ready2", cmd_ready, 0);
    rvalid = 1; rdata = rdat(0); rresp = 0; rlast = 1;
    #1 chk("t3_popfree_ready", cmd_ready, 1); chk("t3_rready", rready, 1);
    sb.push_back({1'b0, rdat(OUTS_NUM)});
    tick();
    cmd_valid = 0;
    #1 chk("t3_cnt_hold", outs_cnt, 8);
    for (int i = 1; i <= OUTS_NUM; i++) begin
      rvalid = 1; rdata = rdat(i);
      tick();
    end
    rvalid = 0;
    #1 chk("t3_cnt0", outs_cnt, 0);

    // Write then read; R arrives before B and must wait
    cmd(0, 32'h2000, 64'h55, 8'hFF, 3'd3);
    sb.push_back({1'b0, 64'h0});
    tick();
    cmd(1, 32'h3000, '0, '0, 3'd3);
    sb.push_back({1'b0, 64'h1111});
    #1 chk("t4_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    tick();
    rvalid = 1; rdata = 64'h1111; rlast = 1;
    #1 chk("t4_rready_stall", rready, 0); chk("t4_rsp_idle", rsp_valid, 0);
    tick();
    #1 chk("t4_rready_stall2", rready, 0);
    bvalid = 1; bresp = 0;
    #1 chk("t4_bready", bready, 1); chk("t4_rready_b", rready, 0); chk("t4_rsp_b", rsp_valid, 1);
    tick();
    bvalid = 0;
    #1 chk("t4_rready_go", rready, 1);
    tick();
    rvalid = 0;
    #1 chk("t4_cnt0", outs_cnt, 0);

    // Missing rlast: error response and sticky protocol flag
    cmd(1, 32'h4000, '0, '0, 3'd3);
    sb.push_back({1'b1, 64'hAAAA});
    tick();
    cmd_valid = 0;
    tick();
    rvalid = 1; rdata = 64'hAAAA; rlast = 0;
    tick();
    rvalid = 0; rlast = 1;
    #1 chk("t5_proto_set", proto_err, 1);
    cmd(1, 32'h4008, '0, '0, 3'd3);
    sb.push_back({1'b0, 64'h5555});
    tick();
    cmd_valid = 0;
    tick();
    rvalid = 1; rdata = 64'h5555;
    tick();
    rvalid = 0;
    #1 chk("t5_proto_sticky", proto_err, 1);

    // Asynchronous reset with transactions in flight
    cmd(1, 32'h5000, '0, '0, 3'd3); tick();
    cmd(1, 32'h5008, '0, '0, 3'd3); tick();
    awready = 0; wready = 0;
    cmd(0, 32'h6000, 64'h77, 8'hFF, 3'd3); tick();
    cmd_valid = 0;
    #1 chk("t6_awvalid", awvalid, 1); chk("t6_cnt3", outs_cnt, 3);
    rst = 0;
    #1 chk("t6_rst_aw", awvalid, 0); chk("t6_rst_w", wvalid, 0); chk("t6_rst_ar", arvalid, 0);
    chk("t6_rst_cnt", outs_cnt, 0); chk("t6_rst_rsp", rsp_valid, 0); chk("t6_rst_proto", proto_err, 0);
    tick();
    rst = 1; awready = 1; wready = 1;
    tick();
    cmd(1, 32'h7000, '0, '0, 3'd3);
    sb.push_back({1'b0, 64'h7777});
    tick();
    cmd_valid = 0;
    #1 chk("t6_arvalid", arvalid, 1); chk("t6_cnt1", outs_cnt, 1);
    tick();
    rvalid = 1; rdata = 64'h7777; rlast = 1;
    tick();
    rvalid = 0;
    #1 chk("t6_cnt0", outs_cnt, 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
